// File: rtl/la_capture_ctrl.sv
// Capture/trigger controller for the 4-channel logic analyzer: circular write into the sample RAMs,
// pre-trigger window, trigger detection, record start report. LA_INPUT_SYNC_EN adds a 2-flop din synchronizer.
//
// state | meaning
// IDLE  | no capture, strobes ignored
// PRE   | filling the pre-trigger window, trigger ignored
// WAIT  | writing circularly, evaluating trigger on each strobe
// POST  | writing the post-trigger samples
// DONE  | record complete, addresses held until arm or abort
module la_capture_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int CH         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [CH-1:0]         din,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [CH-1:0]         trig_mask,
    input  logic [CH-1:0]         trig_val,
    input  logic [CH-1:0]         trig_edge,
    input  logic [ADDR_WIDTH-1:0] pre_len,
    output logic [ADDR_WIDTH:0]   addr,
    output logic                  we,
    output logic [CH-1:0]         data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;

    logic [CH-1:0] sample;

`ifdef LA_INPUT_SYNC_EN
    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = din;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
    logic [ADDR_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0]   pre_len_q, pre_len_d;
    logic [CH-1:0]           prev_q, prev_d;
    logic                    first_q, first_d;
    logic [ADDR_WIDTH:0]     addr_q, addr_d;
    logic                    we_q, we_d;
    logic [CH-1:0]           data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    triggered_q, triggered_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;

    logic [CH-1:0]           prev_eff;
    logic                    trig_hit;

    // The first strobe of a capture has no history, so it compares against itself and cannot form an edge.
    assign prev_eff = first_q ? sample : prev_q;

    always_comb begin
        trig_hit = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (trig_mask[i]) begin
                if (sample[i] != trig_val[i]) begin
                    trig_hit = 1'b0;
                end
                if (trig_edge[i] && (prev_eff[i] == trig_val[i])) begin
                    trig_hit = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        pre_len_d    = pre_len_q;
        prev_d       = prev_q;
        first_d      = first_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        data_d       = data_q;
        triggered_d  = triggered_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (abort) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d     = ST_PRE;
                        wp_d        = PTR_ZERO;
                        pre_cnt_d   = PTR_ZERO;
                        pre_len_d   = pre_len;
                        first_d     = 1'b1;
                        triggered_d = 1'b0;
                    end
                end
                ST_PRE: begin
                    if (pre_len_q == PTR_ZERO) begin
                        state_d = ST_WAIT;
                    end else if (sample_en) begin
                        we_d      = 1'b1;
                        addr_d    = {1'b0, wp_q};
                        data_d    = sample;
                        wp_d      = wp_q + PTR_ONE;
                        prev_d    = sample;
                        first_d   = 1'b0;
                        pre_cnt_d = pre_cnt_q + PTR_ONE;
                        if (pre_cnt_d == pre_len_q) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sample_en) begin
                        we_d    = 1'b1;
                        addr_d  = {1'b0, wp_q};
                        data_d  = sample;
                        wp_d    = wp_q + PTR_ONE;
                        prev_d  = sample;
                        first_d = 1'b0;
                        if (trig_hit) begin
                            triggered_d  = 1'b1;
                            trig_addr_d  = wp_q;
                            start_addr_d = wp_q - pre_len_q;
                            // DEPTH-1-pre_len samples remain after the trigger sample.
                            post_cnt_d   = PTR_MAX - pre_len_q;
                            state_d      = (post_cnt_d == PTR_ZERO) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        we_d       = 1'b1;
                        addr_d     = {1'b0, wp_q};
                        data_d     = sample;
                        wp_d       = wp_q + PTR_ONE;
                        prev_d     = sample;
                        post_cnt_d = post_cnt_q - PTR_ONE;
                        if (post_cnt_d == PTR_ZERO) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wp_q         <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pre_len_q    <= '0;
            prev_q       <= '0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pre_len_q    <= pre_len_d;
            prev_q       <= prev_d;
            first_q      <= first_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    assign addr       = addr_q;
    assign we         = we_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl (default build): expected writes queued at each strobe, popped by a write monitor.
module tb_la_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  din = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  trig_mask = '0;
    logic [3:0]  trig_val = '0;
    logic [3:0]  trig_edge = '0;
    logic [12:0] pre_len = '0;
    logic [13:0] addr;
    logic        we;
    logic [3:0]  data;
    logic        busy;
    logic        triggered;
    logic        done;
    logic [12:0] trig_addr;
    logic [12:0] start_addr;

    typedef struct packed {
        logic [13:0] addr;
        logic [3:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_cnt = 0;

    la_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din),
        .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_val(trig_val),
        .trig_edge(trig_edge), .pre_len(pre_len), .addr(addr), .we(we),
        .data(data), .busy(busy), .triggered(triggered), .done(done),
        .trig_addr(trig_addr), .start_addr(start_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected addr=%0d data=%h want no write", addr, data);
            end else begin
                e = exp_q.pop_front();
                if (addr !== e.addr || data !== e.data) begin
                    errors++;
                    $display("FAIL wr_content got addr=%0d data=%h want addr=%0d data=%h",
                             addr, data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d, input bit expect_wr, input int k);
        din = d;
        sample_en = 1'b1;
        if (expect_wr) exp_q.push_back('{addr: {1'b0, 13'(k)}, data: d});
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({addr, we, data, busy, triggered, done, trig_addr, start_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%0d we=%b data=%h busy=%b trig=%b done=%b ta=%0d sa=%0d want all 0",
                     addr, we, data, busy, triggered, done, trig_addr, start_addr);
        end
        rst_n = 1'b1;
        tick();
        strobe(4'hA, 1'b0, 0);
        checks++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got we=%b busy=%b want 0 0", we, busy);
        end
    endtask

    task automatic test_immediate();
        int base;
        pre_len = 13'd0; trig_mask = 4'h0; trig_val = 4'h0; trig_edge = 4'h0;
        pulse_arm();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL imm_arm got busy=%b done=%b want 1 0", busy, done);
        end
        base = wr_cnt;
        strobe(4'($urandom), 1'b0, 0);
        for (int k = 0; k < 8192; k++) begin
            strobe(4'($urandom), 1'b1, k);
            if (k == 0) begin
                checks++;
                if (triggered !== 1'b1 || trig_addr !== 13'd0) begin
                    errors++;
                    $display("FAIL imm_trig got triggered=%b trig_addr=%0d want 1 0", triggered, trig_addr);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || start_addr !== 13'd0 || trig_addr !== 13'd0) begin
            errors++;
            $display("FAIL imm_done got done=%b busy=%b sa=%0d ta=%0d want 1 0 0 0", done, busy, start_addr, trig_addr);
        end
        strobe(4'($urandom), 1'b0, 0);
        checks++;
        if (we !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL imm_hold got we=%b done=%b want 0 1", we, done);
        end
        checks++;
        if (wr_cnt - base !== 8192 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL imm_count got writes=%0d pending=%0d want 8192 0", wr_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_level_pre();
        int base;
        pre_len = 13'd100; trig_mask = 4'b0001; trig_val = 4'b0001; trig_edge = 4'b0000;
        pulse_arm();
        base = wr_cnt;
        for (int k = 0; k <= 8591; k++) begin
            logic [3:0] d;
            d = 4'($urandom);
            if (k < 500) d[0] = 1'b0;
            if (k == 500) d[0] = 1'b1;
            strobe(d, 1'b1, k);
            if (k == 499) begin
                checks++;
                if (triggered !== 1'b0) begin
                    errors++;
                    $display("FAIL lvl_early got triggered=%b want 0", triggered);
                end
            end
            if (k == 500) begin
                checks++;
                if (triggered !== 1'b1 || trig_addr !== 13'd500 || start_addr !== 13'd400) begin
                    errors++;
                    $display("FAIL lvl_trig got triggered=%b ta=%0d sa=%0d want 1 500 400", triggered, trig_addr, start_addr);
                end
            end
            if (k == 8590) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL lvl_not_done got done=%b busy=%b want 0 1", done, busy);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || addr !== 14'd399) begin
            errors++;
            $display("FAIL lvl_done got done=%b busy=%b last_addr=%0d want 1 0 399", done, busy, addr);
        end
        strobe(4'($urandom), 1'b0, 0);
        checks++;
        if (wr_cnt - base !== 8592 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL lvl_count got writes=%0d pending=%0d want 8592 0", wr_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_edge_wrap();
        pre_len = 13'd8191; trig_mask = 4'b0010; trig_val = 4'b0010; trig_edge = 4'b0010;
        pulse_arm();
        for (int k = 0; k <= 10000; k++) begin
            logic [3:0] d;
            d = 4'($urandom);
            d[1] = (k < 9000) || (k >= 10000);
            strobe(d, 1'b1, k);
            if (k == 9999) begin
                checks++;
                if (triggered !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL edge_early got triggered=%b busy=%b want 0 1", triggered, busy);
                end
            end
        end
        checks++;
        if (triggered !== 1'b1 || done !== 1'b1 || busy !== 1'b0 ||
            trig_addr !== 13'd1808 || start_addr !== 13'd1809) begin
            errors++;
            $display("FAIL edge_trig got trig=%b done=%b busy=%b ta=%0d sa=%0d want 1 1 0 1808 1809",
                     triggered, done, busy, trig_addr, start_addr);
        end
        strobe(4'($urandom), 1'b0, 0);
        checks++;
        if (we !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL edge_stop got we=%b pending=%0d want 0 0", we, exp_q.size());
        end
    endtask

    task automatic test_pre_blocks();
        pre_len = 13'd50; trig_mask = 4'b0001; trig_val = 4'b0001; trig_edge = 4'b0000;
        pulse_arm();
        for (int k = 0; k <= 50; k++) begin
            strobe(4'($urandom) | 4'b0001, 1'b1, k);
            if (k == 49) begin
                checks++;
                if (triggered !== 1'b0) begin
                    errors++;
                    $display("FAIL preblk_early got triggered=%b want 0", triggered);
                end
            end
        end
        checks++;
        if (triggered !== 1'b1 || trig_addr !== 13'd50 || start_addr !== 13'd0) begin
            errors++;
            $display("FAIL preblk_trig got trig=%b ta=%0d sa=%0d want 1 50 0", triggered, trig_addr, start_addr);
        end
    endtask

    task automatic test_abort_post();
        for (int k = 51; k <= 70; k++) strobe(4'($urandom), 1'b1, k);
        abort = 1'b1;
        strobe(4'($urandom), 1'b0, 0);
        abort = 1'b0;
        checks++;
        if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL abort_post got we=%b busy=%b done=%b trig=%b want 0 0 0 0", we, busy, done, triggered);
        end
        pre_len = 13'd3; trig_mask = 4'h0;
        pulse_arm();
        strobe(4'h5, 1'b1, 0);
        checks++;
        if (addr !== 14'd0 || we !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_wp got addr=%0d we=%b busy=%b want 0 1 1", addr, we, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort got busy=%b done=%b want 0 0", busy, done);
        end
        strobe(4'hF, 1'b0, 0);
        checks++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_idle got we=%b busy=%b want 0 0", we, busy);
        end
    endtask

    task automatic test_reset_wait();
        pre_len = 13'd2; trig_mask = 4'b0001; trig_val = 4'b0001; trig_edge = 4'b0000;
        pulse_arm();
        for (int k = 0; k < 10; k++) strobe(4'($urandom) & 4'b1110, 1'b1, k);
        strobe(4'b0110, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({addr, we, data, busy, triggered, done, trig_addr, start_addr} !== '0) begin
            errors++;
            $display("FAIL rst_wait got addr=%0d we=%b data=%h busy=%b trig=%b done=%b ta=%0d sa=%0d want all 0",
                     addr, we, data, busy, triggered, done, trig_addr, start_addr);
        end
        sample_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) strobe(4'($urandom), 1'b0, 0);
        checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got busy=%b we=%b want 0 0", busy, we);
        end
        pulse_arm();
        strobe(4'h8, 1'b1, 0);
        strobe(4'h4, 1'b1, 1);
        checks++;
        if (busy !== 1'b1 || addr !== 14'd1) begin
            errors++;
            $display("FAIL rst_rearm got busy=%b addr=%0d want 1 1", busy, addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_writes got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_level_pre();
        test_edge_wrap();
        test_pre_blocks();
        test_abort_post();
        test_reset_wait();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
